// File: rtl/pc_unit.sv
// Program-counter unit for the Mini-MIPS fetch stage: BOOT/RUN/HALT control, next-PC select and EPC capture.
// Define PC_RAS_EN to build the optional circular return-address stack used by jump-and-link/return hints.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(32'h0000_0080),
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            exception,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_valid,
  output logic [XLEN-1:0] epc,
  output logic            halted,
  output logic            misalign
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            misalign_q, misalign_d;
  logic            jump_fire;
  logic            ras_hit;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] jump_dest;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

  assign pc_plus4  = pc_q + XLEN'(4);
  assign jump_fire = (state_q == RUN) && !exception && jump;
  assign jump_dest = ras_hit ? ras_top : jump_target;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    misalign_d = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        pc_d    = RESET_VECTOR;
      end
      RUN: begin
        if (exception) begin
          pc_d  = EXC_VECTOR;
          epc_d = pc_q;
        end else begin
          if (jump) begin
            pc_d       = word_align(jump_dest);
            misalign_d = |jump_dest[1:0];
          end else if (branch_taken) begin
            pc_d       = word_align(branch_target);
            misalign_d = |branch_target[1:0];
          end else if (!stall && !halt_req) begin
            // entering HALT freezes the unconsumed fetch address so resume refetches it
            pc_d = pc_plus4;
          end
          if (halt_req) state_d = HALT;
        end
      end
      HALT: begin
        if (exception) begin
          pc_d    = EXC_VECTOR;
          epc_d   = pc_q;
          state_d = RUN;
        end else if (resume) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef PC_RAS_EN
  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] ras_mem_q [RAS_DEPTH];
  logic [PW-1:0]   top_q, top_inc, top_dec;
  logic [CW-1:0]   cnt_q;
  logic            ras_clear;

  assign ras_clear = exception && (state_q != BOOT);
  assign ras_hit   = jump_fire && ras_pop && (cnt_q != '0);
  assign ras_top   = ras_mem_q[top_q];
  assign top_inc   = (top_q == PW'(RAS_DEPTH - 1)) ? '0 : top_q + PW'(1);
  assign top_dec   = (top_q == '0) ? PW'(RAS_DEPTH - 1) : top_q - PW'(1);

  // top_q always names the newest entry; a push when full silently reuses the oldest slot
  always_ff @(posedge clk) begin
    if (rst || ras_clear) begin
      top_q <= PW'(RAS_DEPTH - 1);
      cnt_q <= '0;
    end else if (jump_fire) begin
      if (ras_push && !ras_hit) begin
        top_q <= top_inc;
        if (cnt_q != CW'(RAS_DEPTH)) cnt_q <= cnt_q + CW'(1);
      end else if (!ras_push && ras_hit) begin
        top_q <= top_dec;
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && jump_fire && ras_push) begin
      if (ras_hit) ras_mem_q[top_q]   <= pc_plus4;
      else         ras_mem_q[top_inc] <= pc_plus4;
    end
  end
`else
  logic unused_ras;
  assign unused_ras = ras_push ^ ras_pop;
  assign ras_hit    = 1'b0;
  assign ras_top    = '0;
`endif

  assign pc       = pc_q;
  assign epc      = epc_q;
  assign misalign = misalign_q;
  assign pc_valid = (state_q == RUN);
  assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_pc_unit.sv
// Table-driven, scoreboarded bench for pc_unit; the stack rows are included when PC_RAS_EN is defined.
module tb_pc_unit;
  localparam int C_RST = 1, C_ST = 2, C_BR = 4, C_JMP = 8, C_EXC = 16,
                 C_HLT = 32, C_RES = 64, C_PSH = 128, C_POP = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, exception = 1'b0;
  logic        halt_req = 1'b0, resume = 1'b0, ras_push = 1'b0, ras_pop = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0;
  logic [31:0] pc, pc_plus4, epc;
  logic        pc_valid, halted, misalign;

  always #5 clk = ~clk;

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h80), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .exception(exception), .halt_req(halt_req), .resume(resume),
    .ras_push(ras_push), .ras_pop(ras_pop), .pc(pc), .pc_plus4(pc_plus4),
    .pc_valid(pc_valid), .epc(epc), .halted(halted), .misalign(misalign)
  );

  typedef struct {
    int          c;
    logic [31:0] jt, bt, pc;
    logic        v, h;
    logic [31:0] epc;
    logic        mis;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic add(input int c, input logic [31:0] jt, input logic [31:0] bt,
                     input logic [31:0] epc_pc, input logic v, input logic h,
                     input logic [31:0] e, input logic mis);
    vec_t r;
    r.c = c; r.jt = jt; r.bt = bt; r.pc = epc_pc; r.v = v; r.h = h; r.epc = e; r.mis = mis;
    vecs.push_back(r);
  endtask

  task automatic drive(input vec_t r);
    rst           = (r.c & C_RST) != 0;
    stall         = (r.c & C_ST)  != 0;
    branch_taken  = (r.c & C_BR)  != 0;
    jump          = (r.c & C_JMP) != 0;
    exception     = (r.c & C_EXC) != 0;
    halt_req      = (r.c & C_HLT) != 0;
    resume        = (r.c & C_RES) != 0;
    ras_push      = (r.c & C_PSH) != 0;
    ras_pop       = (r.c & C_POP) != 0;
    jump_target   = r.jt;
    branch_target = r.bt;
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_out(input int idx);
    vec_t e;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard row %0d: got empty queue expected an entry", idx);
      return;
    end
    e = sb.pop_front();
    check("pc",       idx, pc,               e.pc);
    check("pc_plus4", idx, pc_plus4,         e.pc + 32'd4);
    check("pc_valid", idx, {31'b0, pc_valid}, {31'b0, e.v});
    check("halted",   idx, {31'b0, halted},   {31'b0, e.h});
    check("epc",      idx, epc,              e.epc);
    check("misalign", idx, {31'b0, misalign}, {31'b0, e.mis});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t hw;
    //  ctrl                     jt            bt       pc            v  h  epc     mis
    add(C_RST,                   0,            0,       0,            0, 0, 0,      0);
    add(C_RST,                   0,            0,       0,            0, 0, 0,      0);
    add(0,                       0,            0,       0,            1, 0, 0,      0);
    add(0,                       0,            0,       32'h4,        1, 0, 0,      0);
    add(0,                       0,            0,       32'h8,        1, 0, 0,      0);
    add(C_ST,                    0,            0,       32'h8,        1, 0, 0,      0);
    add(C_ST,                    0,            0,       32'h8,        1, 0, 0,      0);
    add(C_ST | C_BR,             0,            32'h40,  32'h40,       1, 0, 0,      0);
    add(0,                       0,            0,       32'h44,       1, 0, 0,      0);
    add(C_JMP,                   32'h10,       0,       32'h10,       1, 0, 0,      0);
    add(C_EXC | C_JMP | C_BR,    32'h200,      32'h300, 32'h80,       1, 0, 32'h10, 0);
    add(0,                       0,            0,       32'h84,       1, 0, 32'h10, 0);
    add(C_JMP,                   32'h103,      0,       32'h100,      1, 0, 32'h10, 1);
    add(0,                       0,            0,       32'h104,      1, 0, 32'h10, 0);
    add(C_BR,                    0,            32'h22,  32'h20,       1, 0, 32'h10, 1);
    add(C_HLT,                   0,            0,       32'h20,       0, 1, 32'h10, 0);
    add(0,                       0,            0,       32'h20,       0, 1, 32'h10, 0);
    add(C_HLT | C_RES,           0,            0,       32'h20,       1, 0, 32'h10, 0);
    add(0,                       0,            0,       32'h24,       1, 0, 32'h10, 0);
    add(C_HLT,                   0,            0,       32'h24,       0, 1, 32'h10, 0);
    add(C_RST | C_JMP,           32'h300,      0,       0,            0, 0, 0,      0);
    add(0,                       0,            0,       0,            1, 0, 0,      0);
    add(C_JMP,                   32'hFFFFFFFC, 0,       32'hFFFFFFFC, 1, 0, 0,      0);
    add(0,                       0,            0,       0,            1, 0, 0,      0);
    add(C_JMP,                   32'h50,       0,       32'h50,       1, 0, 0,      0);
    add(C_HLT,                   0,            0,       32'h50,       0, 1, 0,      0);
    add(C_EXC,                   0,            0,       32'h80,       1, 0, 32'h50, 0);
`ifdef PC_RAS_EN
    add(C_JMP,                   0,            0,       0,            1, 0, 32'h50, 0);
    add(C_JMP | C_PSH,           32'h10,       0,       32'h10,       1, 0, 32'h50, 0);
    add(C_JMP | C_PSH,           32'h20,       0,       32'h20,       1, 0, 32'h50, 0);
    add(C_JMP | C_PSH,           32'h30,       0,       32'h30,       1, 0, 32'h50, 0);
    add(C_JMP | C_PSH,           32'h40,       0,       32'h40,       1, 0, 32'h50, 0);
    add(C_JMP | C_PSH,           32'h200,      0,       32'h200,      1, 0, 32'h50, 0);
    add(C_JMP | C_POP,           32'h300,      0,       32'h44,       1, 0, 32'h50, 0);
    add(C_JMP | C_POP,           32'h300,      0,       32'h34,       1, 0, 32'h50, 0);
    add(C_JMP | C_POP,           32'h300,      0,       32'h24,       1, 0, 32'h50, 0);
    add(C_JMP | C_POP,           32'h300,      0,       32'h14,       1, 0, 32'h50, 0);
    add(C_JMP | C_POP,           32'h300,      0,       32'h300,      1, 0, 32'h50, 0);
`else
    add(C_JMP | C_PSH,           32'h10,       0,       32'h10,       1, 0, 32'h50, 0);
    add(C_JMP | C_POP,           32'h300,      0,       32'h300,      1, 0, 32'h50, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (i > 0) check_out(i - 1);
      drive(vecs[i]);
      sb.push_back(vecs[i]);
    end
    @(negedge clk);
    check_out(vecs.size() - 1);

    // mid-run reset racing an exception and a jump: everything returns to reset values
    hw = vecs[0];
    hw.c = C_RST | C_EXC | C_JMP; hw.jt = 32'h404;
    drive(hw);
    hw.pc = 0; hw.v = 0; hw.h = 0; hw.epc = 0; hw.mis = 0;
    sb.push_back(hw);
    @(negedge clk);
    check_out(1000);

    // release reset: one BOOT cycle, then sequential fetch from the reset vector
    hw.c = 0;
    drive(hw);
    @(negedge clk);
    check("boot_valid", 1001, {31'b0, pc_valid}, 32'd1);
    check("boot_pc",    1001, pc, 32'h0);
    @(negedge clk);
    check("seq_pc",     1002, pc, 32'h4);
    @(negedge clk);
    check("seq_pc",     1003, pc, 32'h8);
    @(negedge clk);
    check("seq_pc",     1004, pc, 32'hC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
